// File: rtl/gravador_jogadas_pkg.sv
// gravador_jogadas_pkg
//  Shared definitions for the play-sequence recorder: FSM state codes
//  (the numeric values are what the board shows on the hex display),
//  the play width, the default wait-for-play timeout and a one-hot helper.
//  Optional feature macro used by the importing modules: GRAVADOR_ONEHOT_EN.
package gravador_jogadas_pkg;

    localparam int PLAY_W          = 4;
    localparam int TIMEOUT_DEFAULT = 3000;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        GRAVA       = 4'h4,
        PROXIMA     = 4'h5,
        FIM_OK      = 4'hA,
        FIM_TIMEOUT = 4'hD,
        ERRO        = 4'hE
    } estado_t;

    // True when exactly one bit of the play is set.
    function automatic logic is_onehot(input logic [PLAY_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/gravador_jogadas_detector.sv
// detector_jogada
//  Registers the switches every cycle and produces a one-cycle registered
//  pulse when they leave the all-zero value. A value held nonzero produces
//  no further pulses until the switches return to zero.
//  Ports:
//   clock   in   system clock (rising edge)
//   reset   in   synchronous active-high reset
//   chaves  in   player switches
//   jogada  out  registered press pulse, one cycle after the press
module detector_jogada
    import gravador_jogadas_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [PLAY_W-1:0] chaves,
    output logic              jogada
);

    logic [PLAY_W-1:0] chaves_d_reg;
    logic              jogada_reg;
    logic              chaves_zero;
    logic              chaves_d_zero;

    assign chaves_zero   = (chaves == '0);
    assign chaves_d_zero = (chaves_d_reg == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            chaves_d_reg <= '0;
            jogada_reg   <= 1'b0;
        end else begin
            chaves_d_reg <= chaves;
            jogada_reg   <= !chaves_zero && chaves_d_zero;
        end
    end

    assign jogada = jogada_reg;

endmodule

// File: rtl/gravador_jogadas.sv
// gravador_jogadas
//  Writer side of the memory game's play sequence. Each play entered on the
//  switches is written to the sequence RAM at consecutive addresses, starting
//  at 0, until N_JOGADAS plays are stored, the player stops pressing for
//  TIMEOUT_CICLOS cycles, or (optionally) an invalid play is entered.
//  Optional feature: define GRAVADOR_ONEHOT_EN to reject plays that are not
//  one-hot (session ends in ERRO, nothing written for that play). Without it
//  every nonzero play is written and erro is constant 0.
//  Ports:
//   clock, reset  clock and synchronous active-high reset
//   iniciar       start a session (from INICIAL or any final state)
//   chaves        player switches
//   mem_we        one-cycle RAM write strobe per recorded play
//   mem_addr      RAM write address (current play index)
//   mem_data      RAM write data (latched play)
//   gravados      plays written this session
//   pronto        session finished; timeout / erro give the reason
//   leds          mirror of chaves
//   db_estado     FSM state code for the hex display
module gravador_jogadas
    import gravador_jogadas_pkg::*;
#(
    parameter int N_JOGADAS      = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [PLAY_W-1:0] chaves,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PLAY_W-1:0] mem_data,
    output logic [ADDR_W:0]   gravados,
    output logic              pronto,
    output logic              timeout,
    output logic              erro,
    output logic [3:0]        leds,
    output logic [3:0]        db_estado
);

    localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CICLOS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(N_JOGADAS - 1);
    localparam logic [ADDR_W:0]    GRAV_MAX   = (ADDR_W + 1)'(N_JOGADAS);

    estado_t           state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [PLAY_W-1:0] mem_data_reg;
    logic [ADDR_W:0]   gravados_reg;
    logic              pronto_reg;
    logic              timeout_reg;
    logic              jogada;

    detector_jogada u_detector (
        .clock  (clock),
        .reset  (reset),
        .chaves (chaves),
        .jogada (jogada)
    );

`ifdef GRAVADOR_ONEHOT_EN
    logic erro_reg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= INICIAL;
            timer_reg    <= '0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            gravados_reg <= '0;
            pronto_reg   <= 1'b0;
            timeout_reg  <= 1'b0;
`ifdef GRAVADOR_ONEHOT_EN
            erro_reg     <= 1'b0;
`endif
        end else begin
            // The write strobe is only raised on the edge entering GRAVA,
            // so it drops back to 0 on every other edge.
            mem_we_reg <= 1'b0;
            case (state_reg)
                INICIAL: begin
                    if (iniciar) begin
                        state_reg <= PREPARA;
                    end
                end
                PREPARA: begin
                    mem_addr_reg <= '0;
                    gravados_reg <= '0;
                    timer_reg    <= '0;
                    pronto_reg   <= 1'b0;
                    timeout_reg  <= 1'b0;
`ifdef GRAVADOR_ONEHOT_EN
                    erro_reg     <= 1'b0;
`endif
                    state_reg    <= ESPERA;
                end
                ESPERA: begin
                    // A play arriving on the last timer cycle still counts.
                    if (jogada) begin
                        mem_data_reg <= chaves;
                        state_reg    <= REGISTRA;
                        timer_reg    <= timer_reg + 1'b1;
                    end else if (timer_reg == TIMER_LAST) begin
                        pronto_reg  <= 1'b1;
                        timeout_reg <= 1'b1;
                        state_reg   <= FIM_TIMEOUT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                REGISTRA: begin
`ifdef GRAVADOR_ONEHOT_EN
                    if (!is_onehot(mem_data_reg)) begin
                        pronto_reg <= 1'b1;
                        erro_reg   <= 1'b1;
                        state_reg  <= ERRO;
                    end else begin
                        mem_we_reg <= 1'b1;
                        state_reg  <= GRAVA;
                    end
`else
                    mem_we_reg <= 1'b1;
                    state_reg  <= GRAVA;
`endif
                end
                GRAVA: begin
                    if (gravados_reg != GRAV_MAX) begin
                        gravados_reg <= gravados_reg + 1'b1;
                    end
                    // The address never wraps: the last slot ends the session.
                    if (mem_addr_reg == ADDR_LAST) begin
                        pronto_reg <= 1'b1;
                        state_reg  <= FIM_OK;
                    end else begin
                        state_reg <= PROXIMA;
                    end
                end
                PROXIMA: begin
                    mem_addr_reg <= mem_addr_reg + 1'b1;
                    timer_reg    <= '0;
                    state_reg    <= ESPERA;
                end
                FIM_OK, FIM_TIMEOUT, ERRO: begin
                    if (iniciar) begin
                        state_reg <= PREPARA;
                    end
                end
                default: begin
                    state_reg <= INICIAL;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_data  = mem_data_reg;
    assign gravados  = gravados_reg;
    assign pronto    = pronto_reg;
    assign timeout   = timeout_reg;
    assign leds      = chaves;
    assign db_estado = state_reg;
`ifdef GRAVADOR_ONEHOT_EN
    assign erro      = erro_reg;
`else
    assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_gravador_jogadas.sv
// tb_gravador_jogadas
//  Directed bench for the play-sequence recorder: a table of 16 plays for a
//  full session plus hand-written sequences for timeout boundaries, invalid
//  plays, reset mid-session and switches held across start.
module tb_gravador_jogadas;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int T  = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [3:0]    chaves;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_data;
    logic [AW:0]   gravados;
    logic          pronto;
    logic          timeout;
    logic          erro;
    logic [3:0]    leds;
    logic [3:0]    db_estado;

    gravador_jogadas #(
        .N_JOGADAS      (N),
        .ADDR_W         (AW),
        .TIMEOUT_CICLOS (T)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .chaves    (chaves),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .gravados  (gravados),
        .pronto    (pronto),
        .timeout   (timeout),
        .erro      (erro),
        .leds      (leds),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]    chaves;
        logic [3:0]    hist;
        logic [AW-1:0] addr;
        logic [AW:0]   grav;
    } vec_t;

    vec_t       vecs [N];
    int         checks   = 0;
    int         errors   = 0;
    int         we_count = 0;
    logic [3:0] last_addr;
    logic [3:0] last_data;

    // Advance one clock and sample 1 time unit after the edge; every write
    // strobe seen is counted and its address/data kept.
    task automatic tick();
        @(posedge clock);
        #1;
        if (mem_we === 1'b1) begin
            we_count++;
            last_addr = mem_addr;
            last_data = mem_data;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Press a value for 4 cycles then release for 2; hist[k] is mem_we
    // after the k-th edge following the press.
    task automatic press(input logic [3:0] v, output logic [3:0] hist);
        chaves = v;
        for (int k = 0; k < 4; k++) begin
            tick();
            hist[k] = mem_we;
        end
        chaves = 4'b0000;
        tick();
        tick();
    endtask

    // Leaves the FSM having just entered ESPERA with the timer at 0.
    task automatic start();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] h;
        int         wc;

        for (int i = 0; i < N; i++) begin
            vecs[i].chaves = 4'b0001 << (i % 4);
            vecs[i].hist   = 4'b0100;
            vecs[i].addr   = AW'(i);
            vecs[i].grav   = (AW + 1)'(i + 1);
        end

        // Reset state
        reset   = 1'b1;
        iniciar = 1'b0;
        chaves  = 4'b1010;
        tick();
        check("rst_estado", db_estado, 4'h0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_gravados", gravados, 0);
        check("rst_pronto", pronto, 0);
        check("rst_timeout", timeout, 0);
        check("rst_erro", erro, 0);
        check("leds_mirror", leds, 4'b1010);
        chaves = 4'b0000;
        reset  = 1'b0;
        tick();

        // Full session of 16 one-hot plays
        start();
        for (int i = 0; i < N; i++) begin
            wc = we_count;
            press(vecs[i].chaves, h);
            check($sformatf("v%0d_we_timing", i), h, vecs[i].hist);
            check($sformatf("v%0d_we_count", i), we_count - wc, 1);
            check($sformatf("v%0d_addr", i), last_addr, vecs[i].addr);
            check($sformatf("v%0d_data", i), last_data, vecs[i].chaves);
            check($sformatf("v%0d_gravados", i), gravados, vecs[i].grav);
        end
        check("full_pronto", pronto, 1);
        check("full_estado", db_estado, 4'hA);
        check("full_gravados", gravados, N);
        check("full_timeout", timeout, 0);
        check("full_addr_nowrap", mem_addr, N - 1);

        // Restart from FIM_OK; press landing on the last timer cycle
        start();
        check("restart_pronto", pronto, 0);
        check("restart_estado", db_estado, 4'h2);
        check("restart_gravados", gravados, 0);
        repeat (T - 2) tick();
        wc = we_count;
        press(4'b0010, h);
        check("edge_we_timing", h, 4'b0100);
        check("edge_we_count", we_count - wc, 1);
        check("edge_addr", last_addr, 0);
        check("edge_data", last_data, 4'b0010);
        check("edge_timeout", timeout, 0);
        check("edge_pronto", pronto, 0);

        // Timeout with no press
        do_reset();
        wc = we_count;
        start();
        repeat (T - 1) tick();
        check("to_before_timeout", timeout, 0);
        check("to_before_estado", db_estado, 4'h2);
        tick();
        check("to_timeout", timeout, 1);
        check("to_pronto", pronto, 1);
        check("to_estado", db_estado, 4'hD);
        check("to_gravados", gravados, 0);
        check("to_no_write", we_count - wc, 0);
        iniciar = 1'b1;
        tick();
        check("to_restart_prepara", db_estado, 4'h1);
        iniciar = 1'b0;
        tick();
        check("to_restart_timeout", timeout, 0);
        check("to_restart_pronto", pronto, 0);
        check("to_restart_estado", db_estado, 4'h2);
        // Press one cycle too late: timeout wins, nothing written
        repeat (T - 1) tick();
        chaves = 4'b0001;
        tick();
        check("late_estado", db_estado, 4'hD);
        check("late_timeout", timeout, 1);
        tick();
        tick();
        tick();
        chaves = 4'b0000;
        tick();
        check("late_no_write", we_count - wc, 0);
        check("late_estado_hold", db_estado, 4'hD);

        // Non-one-hot play
        do_reset();
        start();
        wc = we_count;
        press(4'b0011, h);
`ifdef GRAVADOR_ONEHOT_EN
        check("inv_we_timing", h, 4'b0000);
        check("inv_we_count", we_count - wc, 0);
        check("inv_erro", erro, 1);
        check("inv_pronto", pronto, 1);
        check("inv_estado", db_estado, 4'hE);
        check("inv_gravados", gravados, 0);
`else
        check("inv_we_timing", h, 4'b0100);
        check("inv_we_count", we_count - wc, 1);
        check("inv_addr", last_addr, 0);
        check("inv_data", last_data, 4'b0011);
        check("inv_erro", erro, 0);
        check("inv_gravados", gravados, 1);
`endif

        // Reset mid-session after 5 writes, with a 6th play in flight
        do_reset();
        start();
        wc = we_count;
        for (int i = 0; i < 5; i++) begin
            press(vecs[i].chaves, h);
        end
        check("mid_five_writes", we_count - wc, 5);
        chaves = 4'b1000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_estado", db_estado, 4'h0);
        check("mid_rst_gravados", gravados, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        chaves = 4'b0000;
        tick();
        press(4'b0001, h);
        press(4'b0010, h);
        check("mid_no_more_writes", we_count - wc, 5);
        check("mid_idle_estado", db_estado, 4'h0);

        // Switches held through start
        do_reset();
        chaves = 4'b0100;
        tick();
        tick();
        wc = we_count;
        start();
        repeat (6) tick();
        check("held_no_write", we_count - wc, 0);
        check("held_estado", db_estado, 4'h2);
        chaves = 4'b0000;
        tick();
        tick();
        press(4'b0100, h);
        check("held_we_timing", h, 4'b0100);
        check("held_we_count", we_count - wc, 1);
        check("held_addr", last_addr, 0);
        check("held_data", last_data, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
